// File: rtl/binary_add_pkg.sv
// ============================================================================
// Module      : binary_add_pkg
// Description : Shared widths and a constant log2 helper for the adder and its
//               result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package binary_add_pkg;

    localparam int ADD_W          = 7;
    localparam int RES_FIFO_DEPTH = 4;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage : binary_add_pkg

`default_nettype wire

// File: rtl/binary_add_res_mem.sv
// ============================================================================
// Module      : binary_add_res_mem
// Description : DEPTH x WIDTH register file, one synchronous write port and
//               one asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_add_res_mem
    import binary_add_pkg::*;
#(
    parameter  int WIDTH  = ADD_W,
    parameter  int DEPTH  = RES_FIFO_DEPTH,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [DEPTH-1:0][WIDTH-1:0] w_words;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] r_word;

        always_ff @(posedge clk) begin
            if (we && (waddr == ADDR_W'(gi))) begin
                r_word <= wdata;
            end
        end

        assign w_words[gi] = r_word;
    end

    assign rdata = w_words[raddr];

endmodule : binary_add_res_mem

`default_nettype wire

// File: rtl/binary_add_result_fifo.sv
// ============================================================================
// Module      : binary_add_result_fifo
// Description : Captures each registered adder sum one cycle after its enable
//               and queues it in a first-word-fall-through valid/ready FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_add_result_fifo
    import binary_add_pkg::*;
#(
    parameter  int WIDTH = ADD_W,
    parameter  int DEPTH = RES_FIFO_DEPTH,
    localparam int CNT_W = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add_en,
    input  logic [WIDTH-1:0] add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             clear_ovf
);

    localparam int               c_ADDR_W   = clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

    logic                r_en_d;
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;

    logic                w_wr;
    logic                w_pop;
    logic                w_accept;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    logic [WIDTH-1:0]    w_rdata;

    // The adder registers its sum on the enable edge, so the sum is stable
    // for sampling one edge later.
    assign w_wr     = r_en_d;
    assign w_full   = (r_count == c_FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_pop    = !w_empty && out_ready;
    // When full, a same-cycle pop frees the head slot, which is exactly the
    // slot the write pointer addresses.
    assign w_accept = w_wr && (!w_full || w_pop);
    assign w_drop   = w_wr && w_full && !w_pop;

    binary_add_res_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_accept),
        .waddr (r_wr_ptr),
        .wdata (add_s),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_d     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_en_d <= add_en;

            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_rdata;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;

endmodule : binary_add_result_fifo

`default_nettype wire
